// File: rtl/stitch_fpu_wb_if.sv
// Stream bundle between the FPU wrapper, the LSU, the FP register file, the
// integer core and the fflags CSR on one side, and the FPU writeback stage on the other.
interface stitch_fpu_wb_if #(
  parameter int FLEN = 64
);
  logic [FLEN-1:0] fpu_result_i;
  logic [4:0]      fpu_status_i;
  logic [6:0]      fpu_tag_i;
  logic            fpu_valid_i;
  logic            fpu_ready_o;
  logic [4:0]      lsu_rd_i;
  logic [FLEN-1:0] lsu_data_i;
  logic            lsu_valid_i;
  logic            lsu_ready_o;
  logic            fpr_we_o;
  logic [4:0]      fpr_waddr_o;
  logic [FLEN-1:0] fpr_wdata_o;
  logic [31:0]     int_rsp_data_o;
  logic [4:0]      int_rsp_rd_o;
  logic            int_rsp_valid_o;
  logic            int_rsp_ready_i;
  logic [4:0]      fflags_o;
  logic            fflags_clear_i;
  logic            busy_o;

  // Handshake rule on every stream: a beat transfers on a rising clock edge
  // where valid and ready are both high; a producer holds valid and its
  // payload stable until that edge.
  modport slave (
    input  fpu_result_i, fpu_status_i, fpu_tag_i, fpu_valid_i,
    output fpu_ready_o,
    input  lsu_rd_i, lsu_data_i, lsu_valid_i,
    output lsu_ready_o,
    output fpr_we_o, fpr_waddr_o, fpr_wdata_o,
    output int_rsp_data_o, int_rsp_rd_o, int_rsp_valid_o,
    input  int_rsp_ready_i,
    output fflags_o,
    input  fflags_clear_i,
    output busy_o
  );

  modport master (
    output fpu_result_i, fpu_status_i, fpu_tag_i, fpu_valid_i,
    input  fpu_ready_o,
    output lsu_rd_i, lsu_data_i, lsu_valid_i,
    input  lsu_ready_o,
    input  fpr_we_o, fpr_waddr_o, fpr_wdata_o,
    input  int_rsp_data_o, int_rsp_rd_o, int_rsp_valid_o,
    output int_rsp_ready_i,
    input  fflags_o,
    output fflags_clear_i,
    input  busy_o
  );
endinterface

// File: rtl/stitch_fpu_wb.sv
// FPU writeback: shares the FP register-file write port with LSU loads,
// queues integer-destination results, and accumulates sticky fflags.
module stitch_fpu_wb #(
  parameter int FLEN         = 64,
  parameter int IntFifoDepth = 2
) (
  input logic              clk_i,
  input logic              rst_ni,
  stitch_fpu_wb_if.slave   bus
);
  localparam int PW = (IntFifoDepth > 1) ? $clog2(IntFifoDepth) : 1;
  localparam int CW = $clog2(IntFifoDepth + 1);
  localparam logic [PW-1:0] LastPtr = PW'(IntFifoDepth - 1);
  localparam logic [CW-1:0] FullCnt = CW'(IntFifoDepth);

  logic            w_is_discard;
  logic            w_is_int;
  logic            w_is_fp;
  logic            w_fpu_req;
  logic            w_gnt_fpu;
  logic            w_gnt_lsu;
  logic            w_fpu_ready;
  logic            w_fpu_hs;
  logic            w_full;
  logic            w_push;
  logic            w_pop;

  logic            r_last_lsu;
  logic            r_we;
  logic [4:0]      r_waddr;
  logic [FLEN-1:0] r_wdata;
  logic [4:0]      r_fflags;
  logic [36:0]     r_mem [IntFifoDepth];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign w_is_discard = bus.fpu_tag_i[6];
  assign w_is_int     = !bus.fpu_tag_i[6] && bus.fpu_tag_i[5];
  assign w_is_fp      = (bus.fpu_tag_i[6:5] == 2'b00);
  assign w_fpu_req    = bus.fpu_valid_i && w_is_fp;

  // Round-robin: on contention, the side that did not win last time goes.
  assign w_gnt_fpu = w_fpu_req && (!bus.lsu_valid_i || r_last_lsu);
  assign w_gnt_lsu = bus.lsu_valid_i && (!w_fpu_req || !r_last_lsu);

  assign w_full = (r_count == FullCnt);

  always_comb begin
    w_fpu_ready = 1'b0;
    if (w_is_discard)  w_fpu_ready = 1'b1;
    else if (w_is_int) w_fpu_ready = !w_full;
    else               w_fpu_ready = w_gnt_fpu;
  end

  assign w_fpu_hs = bus.fpu_valid_i && w_fpu_ready;
  assign w_push   = w_fpu_hs && w_is_int;
  assign w_pop    = (r_count != '0) && bus.int_rsp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_lsu <= 1'b1;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_we <= w_gnt_fpu || w_gnt_lsu;
      if (w_gnt_fpu) begin
        r_last_lsu <= 1'b0;
        r_waddr    <= bus.fpu_tag_i[4:0];
        r_wdata    <= bus.fpu_result_i;
      end else if (w_gnt_lsu) begin
        r_last_lsu <= 1'b1;
        r_waddr    <= bus.lsu_rd_i;
        r_wdata    <= bus.lsu_data_i;
      end
    end
  end

  // A clear in the same cycle as a handshake drops the old flags but keeps the new status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fflags <= '0;
    end else if (w_fpu_hs) begin
      r_fflags <= (bus.fflags_clear_i ? 5'b0 : r_fflags) | bus.fpu_status_i;
    end else if (bus.fflags_clear_i) begin
      r_fflags <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < IntFifoDepth; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {bus.fpu_tag_i[4:0], bus.fpu_result_i[31:0]};
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.fpu_ready_o     = w_fpu_ready;
  assign bus.lsu_ready_o     = w_gnt_lsu;
  assign bus.fpr_we_o        = r_we;
  assign bus.fpr_waddr_o     = r_waddr;
  assign bus.fpr_wdata_o     = r_wdata;
  assign bus.int_rsp_valid_o = (r_count != '0);
  assign bus.int_rsp_rd_o    = r_mem[r_rptr][36:32];
  assign bus.int_rsp_data_o  = r_mem[r_rptr][31:0];
  assign bus.fflags_o        = r_fflags;
  assign bus.busy_o          = r_we || (r_count != '0);
endmodule

// File: doc/stitch_fpu_wb.md
# stitch_fpu_wb

FPU writeback stage that sits directly downstream of the FPU synthesis wrapper. It consumes the wrapper's result/status/tag stream and performs three tasks: it writes FP results to the FP register file write port, which it shares with FP load responses from the LSU; it queues integer-destination results (compares, classify, moves, conversions) toward the integer core; and it accumulates the sticky IEEE exception flags for `fcsr.fflags`.

## Interface
Parameters:
- `FLEN`, 64, FP register width; also the width of the FPU result and LSU data.
- `IntFifoDepth`, 2, entries in the integer-result FIFO; must be ≥1.

Ports:
- `clk_i`  in  1  clock; one clock domain, all state on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `fpu_result_i`  in  FLEN  FPU result.
- `fpu_status_i`  in  5  FPU exception flags {NV,DZ,OF,UF,NX}.
- `fpu_tag_i`  in  7  tag fields:
  - [4:0] destination register index.
  - [5] integer destination.
  - [6] discard result (only the flags are used).
- `fpu_valid_i`  in  1  FPU result valid.
- `fpu_ready_o`  out  1  FPU result accepted.
- `lsu_rd_i`  in  5  FP load destination register.
- `lsu_data_i`  in  FLEN  FP load data, already NaN-boxed.
- `lsu_valid_i` / `lsu_ready_o`  in/out  1  LSU response handshake.
- `fpr_we_o`  out  1  FP register file write enable.
- `fpr_waddr_o`  out  5  FP register file write address.
- `fpr_wdata_o`  out  FLEN  FP register file write data.
- `int_rsp_data_o`  out  32  integer result, equal to `fpu_result_i[31:0]`.
- `int_rsp_rd_o`  out  5  integer destination register.
- `int_rsp_valid_o` / `int_rsp_ready_i`  out/in  1  integer response handshake.
- `fflags_o`  out  5  accumulated sticky flags.
- `fflags_clear_i`  in  1  clears the flags (CSR write).
- `busy_o`  out  1  writeback or integer FIFO holds pending data.

## Operation
FPU result classes, decoded from the tag:
- **Discard** (`tag[6]=1`): `fpu_ready_o=1` unconditionally. Flags are accumulated; the result is dropped. `tag[5]` is ignored.
- **Integer** (`tag[6]=0`, `tag[5]=1`): `fpu_ready_o = !int_fifo_full`. On handshake, {rd, result[31:0]} is pushed into the FIFO.
  - `fpu_ready_o` depends only on the registered full state. There is no combinational path from `int_rsp_ready_i`, so a simultaneous pop and push while full still stalls for one cycle.
- **FP** (`tag[6:5]=00`): competes with the LSU for the single write port, using round-robin arbitration.
  - A `last_grant` flop records the last winner (reset value: LSU). When both requesters are valid, the one not recorded in `last_grant` wins.
  - A lone requester always wins.
  - `fpu_ready_o` / `lsu_ready_o` equal their grant. Non-FP FPU classes never raise the arbiter's FPU request.
- **Write stage**: one register stage. A granted request at edge N drives `fpr_we_o`, `fpr_waddr_o` and `fpr_wdata_o` during cycle N+1. The register file never stalls, so the stage never backpressures.
- **Flags**: on every FPU handshake, regardless of class, `fflags_q <= (fflags_clear_i ? 0 : fflags_q) | fpu_status_i`.
  - Without a handshake, `fflags_clear_i` alone zeroes the flags.
  - When a clear and a handshake happen together, the new status survives.
- **Integer FIFO**: head-of-queue output, with pointer wrap modulo `IntFifoDepth`. An element pushed at edge N is visible at N+1; there is no fall-through path.
- **`busy_o`** = `fpr_we_o` | FIFO non-empty.

## Timing
- Reset values: `fpr_we_o=0`, `fpr_waddr_o=0`, `fpr_wdata_o=0`, `int_rsp_valid_o=0`, `int_rsp_data_o=0`, `int_rsp_rd_o=0`, `fflags_o=0`, `busy_o=0`, `last_grant`=LSU, FIFO empty.
- Ready outputs during reset:
  - `fpu_ready_o` follows the combinational rules above: 1 for discard and integer classes, since the FIFO is empty.
  - `lsu_ready_o` is 1 when the LSU is the only requester.
- Reset asserted mid-operation discards all pending FIFO entries and any write-stage content immediately (asynchronous reset).
- Latency:
  - FP result or load to register file write: 1 cycle.
  - Integer result to `int_rsp_valid_o`: 1 cycle (minimum).
  - Flags: `fflags_o` is updated 1 cycle after the handshake.
- Handshake rules:
  - Valid/ready on all streams; a transfer happens when valid and ready are both high on a rising edge.
  - `int_rsp_valid_o` stays high, with stable data, until `int_rsp_ready_i`.
- Throughput: one FP register file write per cycle. Integer results: one per cycle while the FIFO is not full.

## Test plan
- **FP result, no contention**: FPU valid, tag=7'b00_00011, result=0x3FF0000000000000, status=5'b00001.
  - `fpu_ready_o=1`.
  - Next cycle: `fpr_we_o=1`, `fpr_waddr_o=3`, `fpr_wdata_o=0x3FF0000000000000`, `fflags_o=5'b00001`.
- **Contention after reset**: FPU (rd 1) and LSU (rd 2) both valid for 4 cycles. Grants go FPU, LSU, FPU, LSU; writes to rd 1, 2, 1, 2 one cycle later; neither requester starves.
- **Integer FIFO backpressure**: `IntFifoDepth=2`, `int_rsp_ready_i=0`, 3 integer results (rd 5, 6, 7).
  - The first two are accepted; `fpu_ready_o=0` on the third.
  - Raising `int_rsp_ready_i` drains rd 5 then rd 6. The third result is accepted the cycle after the first pop, and the responses come out in order.
- **Discard class**: tag[6]=1, status=5'b10000, while the FIFO is full and the LSU holds the port. Accepted immediately; no write or push; `fflags_o=5'b10000`.
- **Clear collision**: with `fflags_o=5'b00011`, assert `fflags_clear_i` together with an FPU handshake carrying status=5'b00100 → `fflags_o=5'b00100`. Clear alone → 0.
- **Reset mid-operation**: with the FIFO holding 2 entries and `fpr_we_o=1`, pulse `rst_ni` low asynchronously → all outputs return to their reset values before the next edge; `busy_o=0`.
